// File: rtl/dual_issue_split_pkg.sv
// Shared widths and FSM encodings for the dual-issue splitter.
// DS_R0_FILTER_EN (optional) drops hazards on writes to register 0.
package dual_issue_split_pkg;

  localparam int DS_AWIDTH  = 5;
  localparam int DS_IWIDTH  = 32;
  localparam int DS_PCWIDTH = 32;

  typedef enum logic {
    DS_PASS = 1'b0,
    DS_HOLD = 1'b1
  } ds_state_e;

endpackage

// File: rtl/dual_issue_split_pair_hazard.sv
// Intra-pair RAW compare: slot 1 reads what slot 0 writes.
// DS_R0_FILTER_EN: a slot 0 write to register 0 never raises a hazard.
module pair_hazard #(
  parameter int AWIDTH = 5
) (
  input  logic              v0_i,
  input  logic              v1_i,
  input  logic              we_0_i,
  input  logic [AWIDTH-1:0] rd_0_i,
  input  logic [AWIDTH-1:0] rs_1_i,
  input  logic [AWIDTH-1:0] rt_1_i,
  input  logic              rs_use_1_i,
  input  logic              rt_use_1_i,
  output logic              hazard_o
);

  logic rd_live;
  logic rs_hit;
  logic rt_hit;

`ifdef DS_R0_FILTER_EN
  assign rd_live = |rd_0_i;
`else
  assign rd_live = 1'b1;
`endif

  assign rs_hit = rs_use_1_i & (rd_0_i == rs_1_i);
  assign rt_hit = rt_use_1_i & (rd_0_i == rt_1_i);

  assign hazard_o = v0_i & v1_i & we_0_i & rd_live
                  & (rs_hit | rt_hit);

endmodule

// File: rtl/dual_issue_split.sv
// Issue-side pair splitter: one output register stage, RAW split via hold.
// DS_R0_FILTER_EN (optional) is applied inside pair_hazard.
module dual_issue_split
  import dual_issue_split_pkg::*;
#(
  parameter int AWIDTH  = DS_AWIDTH,
  parameter int IWIDTH  = DS_IWIDTH,
  parameter int PCWIDTH = DS_PCWIDTH
) (
  input  logic               ds_i_clk,
  input  logic               ds_i_rst,
  input  logic               ds_i_flush,
  input  logic               ds_i_valid,
  output logic               ds_o_ready,
  input  logic               ds_i_v0,
  input  logic               ds_i_v1,
  input  logic [IWIDTH-1:0]  ds_i_instr_0,
  input  logic [IWIDTH-1:0]  ds_i_instr_1,
  input  logic [PCWIDTH-1:0] ds_i_pc_0,
  input  logic [PCWIDTH-1:0] ds_i_pc_1,
  input  logic               ds_i_we_0,
  input  logic [AWIDTH-1:0]  ds_i_addr_rd_0,
  input  logic [AWIDTH-1:0]  ds_i_addr_rs_1,
  input  logic [AWIDTH-1:0]  ds_i_addr_rt_1,
  input  logic               ds_i_rs_use_1,
  input  logic               ds_i_rt_use_1,
  output logic               ds_o_valid,
  input  logic               ds_i_ready,
  output logic               ds_o_v0,
  output logic               ds_o_v1,
  output logic [IWIDTH-1:0]  ds_o_instr_0,
  output logic [IWIDTH-1:0]  ds_o_instr_1,
  output logic [PCWIDTH-1:0] ds_o_pc_0,
  output logic [PCWIDTH-1:0] ds_o_pc_1,
  output logic               ds_o_split
);

  ds_state_e          state_q, state_d;
  logic               valid_q, valid_d;
  logic               v0_q, v0_d;
  logic               v1_q, v1_d;
  logic               split_q, split_d;
  logic [IWIDTH-1:0]  instr0_q, instr0_d;
  logic [IWIDTH-1:0]  instr1_q, instr1_d;
  logic [PCWIDTH-1:0] pc0_q, pc0_d;
  logic [PCWIDTH-1:0] pc1_q, pc1_d;
  logic [IWIDTH-1:0]  hinstr_q, hinstr_d;
  logic [PCWIDTH-1:0] hpc_q, hpc_d;

  logic hazard;
  logic accept;
  logic drain;

  pair_hazard #(
    .AWIDTH(AWIDTH)
  ) u_hazard (
    .v0_i       (ds_i_v0),
    .v1_i       (ds_i_v1),
    .we_0_i     (ds_i_we_0),
    .rd_0_i     (ds_i_addr_rd_0),
    .rs_1_i     (ds_i_addr_rs_1),
    .rt_1_i     (ds_i_addr_rt_1),
    .rs_use_1_i (ds_i_rs_use_1),
    .rt_use_1_i (ds_i_rt_use_1),
    .hazard_o   (hazard)
  );

  assign ds_o_ready = (state_q == DS_PASS)
                    & (~valid_q | ds_i_ready)
                    & ~ds_i_flush;
  assign accept = ds_i_valid & ds_o_ready;
  assign drain  = valid_q & ds_i_ready;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    split_d  = split_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    hinstr_d = hinstr_q;
    hpc_d    = hpc_q;
    if (ds_i_flush) begin
      state_d  = DS_PASS;
      valid_d  = 1'b0;
      v0_d     = 1'b0;
      v1_d     = 1'b0;
      split_d  = 1'b0;
      hinstr_d = '0;
      hpc_d    = '0;
    end else begin
      unique case (state_q)
        DS_PASS: begin
          if (accept && hazard) begin
            valid_d  = 1'b1;
            v0_d     = 1'b1;
            v1_d     = 1'b0;
            split_d  = 1'b1;
            instr0_d = ds_i_instr_0;
            pc0_d    = ds_i_pc_0;
            instr1_d = '0;
            pc1_d    = '0;
            hinstr_d = ds_i_instr_1;
            hpc_d    = ds_i_pc_1;
            state_d  = DS_HOLD;
          end else if (accept) begin
            valid_d  = 1'b1;
            v0_d     = ds_i_v0;
            v1_d     = ds_i_v1;
            split_d  = 1'b0;
            instr0_d = ds_i_instr_0;
            instr1_d = ds_i_instr_1;
            pc0_d    = ds_i_pc_0;
            pc1_d    = ds_i_pc_1;
          end else if (drain) begin
            valid_d = 1'b0;
            v0_d    = 1'b0;
            v1_d    = 1'b0;
            split_d = 1'b0;
          end
        end
        DS_HOLD: begin
          // Held slot 1 always reissues in lane 0.
          if (drain) begin
            valid_d  = 1'b1;
            v0_d     = 1'b1;
            v1_d     = 1'b0;
            split_d  = 1'b1;
            instr0_d = hinstr_q;
            pc0_d    = hpc_q;
            instr1_d = '0;
            pc1_d    = '0;
            hinstr_d = '0;
            hpc_d    = '0;
            state_d  = DS_PASS;
          end
        end
        default: state_d = DS_PASS;
      endcase
    end
  end

  always_ff @(posedge ds_i_clk or negedge ds_i_rst) begin
    if (!ds_i_rst) begin
      state_q  <= DS_PASS;
      valid_q  <= 1'b0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      split_q  <= 1'b0;
      instr0_q <= '0;
      instr1_q <= '0;
      pc0_q    <= '0;
      pc1_q    <= '0;
      hinstr_q <= '0;
      hpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      split_q  <= split_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      hinstr_q <= hinstr_d;
      hpc_q    <= hpc_d;
    end
  end

  assign ds_o_valid   = valid_q;
  assign ds_o_v0      = v0_q;
  assign ds_o_v1      = v1_q;
  assign ds_o_split   = split_q;
  assign ds_o_instr_0 = instr0_q;
  assign ds_o_instr_1 = instr1_q;
  assign ds_o_pc_0    = pc0_q;
  assign ds_o_pc_1    = pc1_q;

endmodule

// File: tb/tb_dual_issue_split.sv
// Directed bench for dual_issue_split: pass, split, masking, stall, flush, reset.
// Expected R0 behaviour follows DS_R0_FILTER_EN.
module tb_dual_issue_split;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        v0, v1;
  logic [31:0] instr_0, instr_1;
  logic [31:0] pc_0, pc_1;
  logic        we_0;
  logic [4:0]  rd_0, rs_1, rt_1;
  logic        rs_use, rt_use;
  logic        o_valid;
  logic        o_rdy_in;
  logic        o_v0, o_v1;
  logic [31:0] o_instr_0, o_instr_1;
  logic [31:0] o_pc_0, o_pc_1;
  logic        o_split;

  int checks = 0;
  int errors = 0;

  dual_issue_split dut (
    .ds_i_clk       (clk),
    .ds_i_rst       (rst_n),
    .ds_i_flush     (flush),
    .ds_i_valid     (in_valid),
    .ds_o_ready     (in_ready),
    .ds_i_v0        (v0),
    .ds_i_v1        (v1),
    .ds_i_instr_0   (instr_0),
    .ds_i_instr_1   (instr_1),
    .ds_i_pc_0      (pc_0),
    .ds_i_pc_1      (pc_1),
    .ds_i_we_0      (we_0),
    .ds_i_addr_rd_0 (rd_0),
    .ds_i_addr_rs_1 (rs_1),
    .ds_i_addr_rt_1 (rt_1),
    .ds_i_rs_use_1  (rs_use),
    .ds_i_rt_use_1  (rt_use),
    .ds_o_valid     (o_valid),
    .ds_i_ready     (o_rdy_in),
    .ds_o_v0        (o_v0),
    .ds_o_v1        (o_v1),
    .ds_o_instr_0   (o_instr_0),
    .ds_o_instr_1   (o_instr_1),
    .ds_o_pc_0      (o_pc_0),
    .ds_o_pc_1      (o_pc_1),
    .ds_o_split     (o_split)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic pair(input logic a0, input logic a1,
                      input logic we,
                      input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic rsu, input logic rtu,
                      input logic [31:0] base);
    v0       = a0;
    v1       = a1;
    we_0     = we;
    rd_0     = rd;
    rs_1     = rs;
    rt_1     = rt;
    rs_use   = rsu;
    rt_use   = rtu;
    instr_0  = base;
    instr_1  = base + 32'h1;
    pc_0     = base + 32'h100;
    pc_1     = base + 32'h104;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic vld,
                      input logic a0, input logic a1,
                      input logic sp, input logic [31:0] p0);
    chk({tag, "_vld"}, 64'(o_valid), 64'(vld));
    chk({tag, "_v0"}, 64'(o_v0), 64'(a0));
    chk({tag, "_v1"}, 64'(o_v1), 64'(a1));
    chk({tag, "_split"}, 64'(o_split), 64'(sp));
    chk({tag, "_pc0"}, 64'(o_pc_0), 64'(p0));
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    o_rdy_in = 1'b1;
    pair(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    in_valid = 1'b0;
    #2;
    beat("rst", 0, 0, 0, 0, 32'h0);
    chk("rst_instr0", 64'(o_instr_0), 64'h0);
    chk("rst_rdy", 64'(in_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // no hazard, one cycle latency
    @(negedge clk);
    pair(1, 1, 1, 5'd3, 5'd4, 5'd5, 1, 1, 32'h1000);
    #1 chk("nh_rdy", 64'(in_ready), 64'h1);
    tick();
    beat("nh", 1, 1, 1, 0, 32'h1100);
    chk("nh_pc1", 64'(o_pc_1), 64'h1104);
    chk("nh_i1", 64'(o_instr_1), 64'h1001);
    // back-to-back accept while previous beat drains
    @(negedge clk);
    pair(1, 1, 1, 5'd3, 5'd4, 5'd5, 1, 1, 32'h1800);
    #1 chk("b2b_rdy", 64'(in_ready), 64'h1);
    tick();
    beat("b2b", 1, 1, 1, 0, 32'h1900);
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("nh_drain", 64'(o_valid), 64'h0);

    // rs hazard
    @(negedge clk);
    pair(1, 1, 1, 5'd8, 5'd8, 5'd2, 1, 1, 32'h2000);
    tick();
    beat("rs_b1", 1, 1, 0, 1, 32'h2100);
    chk("rs_hold_rdy", 64'(in_ready), 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    beat("rs_b2", 1, 1, 0, 1, 32'h2104);
    chk("rs_b2_i0", 64'(o_instr_0), 64'h2001);
    chk("rs_pass_rdy", 64'(in_ready), 64'h1);
    tick();
    chk("rs_drain", 64'(o_valid), 64'h0);

    // rt match masked by rt_use=0
    @(negedge clk);
    pair(1, 1, 1, 5'd8, 5'd1, 5'd8, 1, 0, 32'h3000);
    tick();
    beat("mask", 1, 1, 1, 0, 32'h3100);
    // JR rs=31 on slot 1
    @(negedge clk);
    pair(1, 1, 1, 5'd31, 5'd31, 5'd0, 1, 0, 32'h3800);
    tick();
    beat("jr_b1", 1, 1, 0, 1, 32'h3900);
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    beat("jr_b2", 1, 1, 0, 1, 32'h3904);
    tick();

    // v1-only pair passes through
    @(negedge clk);
    pair(0, 1, 1, 5'd6, 5'd6, 5'd6, 1, 1, 32'h3c00);
    tick();
    beat("v1only", 1, 0, 1, 0, 32'h3d00);
    @(negedge clk);
    in_valid = 1'b0;
    tick();

    // backpressure on split pair
    @(negedge clk);
    o_rdy_in = 1'b0;
    pair(1, 1, 1, 5'd9, 5'd0, 5'd9, 0, 1, 32'h4000);
    tick();
    beat("bp_b1", 1, 1, 0, 1, 32'h4100);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      beat($sformatf("bp_hold%0d", i), 1, 1, 0, 1, 32'h4100);
    end
    @(negedge clk);
    o_rdy_in = 1'b1;
    tick();
    beat("bp_b2", 1, 1, 0, 1, 32'h4104);
    tick();
    chk("bp_drain", 64'(o_valid), 64'h0);

    // flush while holding slot 1
    @(negedge clk);
    o_rdy_in = 1'b0;
    pair(1, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0, 32'h5000);
    tick();
    beat("fl_b1", 1, 1, 0, 1, 32'h5100);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    beat("fl_out", 0, 0, 0, 0, 32'h5100);
    chk("fl_rdy", 64'(in_ready), 64'h1);
    @(negedge clk);
    o_rdy_in = 1'b1;
    tick();
    tick();
    chk("fl_noslot1", 64'(o_valid), 64'h0);

    // flush beats a simultaneous accept
    @(negedge clk);
    pair(1, 1, 1, 5'd3, 5'd4, 5'd5, 1, 1, 32'h5800);
    flush = 1'b1;
    #1 chk("flp_rdy", 64'(in_ready), 64'h0);
    tick();
    chk("flp_vld", 64'(o_valid), 64'h0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;

    // async reset mid-HOLD
    @(negedge clk);
    o_rdy_in = 1'b0;
    pair(1, 1, 1, 5'd10, 5'd10, 5'd0, 1, 0, 32'h6000);
    tick();
    chk("ar_hold_rdy", 64'(in_ready), 64'h0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    beat("ar", 0, 0, 0, 0, 32'h0);
    chk("ar_instr0", 64'(o_instr_0), 64'h0);
    chk("ar_rdy", 64'(in_ready), 64'h1);
    @(negedge clk);
    rst_n    = 1'b1;
    o_rdy_in = 1'b1;
    tick();
    tick();
    chk("ar_noslot1", 64'(o_valid), 64'h0);

    // rd_0 = 0
    @(negedge clk);
    pair(1, 1, 1, 5'd0, 5'd0, 5'd1, 1, 0, 32'h7000);
    tick();
`ifdef DS_R0_FILTER_EN
    beat("r0", 1, 1, 1, 0, 32'h7100);
`else
    beat("r0", 1, 1, 0, 1, 32'h7100);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
